// File: rtl/cfi_pkg.sv
// Shared types and constants for the CFI backend shadow stack.
package cfi_pkg;

   localparam int unsigned XLEN = 32;

   // Bit positions inside cfi_log_t.flags (exactly one set for a well-formed log)
   localparam int unsigned FLAG_BRANCH = 3;
   localparam int unsigned FLAG_JUMP   = 2;
   localparam int unsigned FLAG_CALL   = 1;
   localparam int unsigned FLAG_RETURN = 0;

   // Cause code reported when a return target does not match the shadow stack
   localparam logic [XLEN-1:0] CFI_FAULT_CAUSE = 32'h0000_0012;

   typedef struct packed {
      logic [3:0]      flags;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] next_pc;
      logic [XLEN-1:0] target;
   } cfi_log_t;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FAULT
   } cfi_state_e;

   function automatic logic is_onehot4(input logic [3:0] f);
      return (f != 4'b0000) && ((f & (f - 4'b0001)) == 4'b0000);
   endfunction

   function automatic int unsigned max4(input int unsigned a, b, c, d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/cfi_sstack.sv
// Circular shadow-stack storage: push/pop/flush, occupancy, sticky overflow.
// A push onto a full stack overwrites the oldest entry and keeps count at DEPTH.
module cfi_sstack
   import cfi_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [XLEN-1:0]        push_data_i,
   input  logic                   pop_i,
   output logic [XLEN-1:0]        top_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   overflow_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d, top_idx;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;

   // ptr_q is the next write slot; when full it also points at the oldest entry
   assign top_idx    = ptr_q - PW'(1);
   assign top_o      = mem_q[top_idx];
   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;

   // Next pointer/count: flush first, then push, then pop (never both from the FSM)
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (flush_i) begin
         ptr_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (push_i) begin
         ptr_d = ptr_q + PW'(1);
         if (full_o) ovf_d = 1'b1;
         else        cnt_d = cnt_q + CW'(1);
      end else if (pop_i && !empty_o) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Pointer, occupancy and overflow registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Entry storage; contents are only meaningful below the occupancy count
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/cfi_backend_sstack.sv
// CFI backend: drains the control-flow log queue, keeps a shadow stack of
// call return addresses and reports a fault on a mismatching/underflowing return.
// Optional macro CFI_BACKEND_PERF_EN adds saturating call/return/fault counters.
module cfi_backend_sstack
   import cfi_pkg::*;
#(
   parameter int unsigned SSTACK_DEPTH       = 16,
   parameter int unsigned NR_STALL_BRANCH    = 1,
   parameter int unsigned NR_STALL_JUMP      = 1,
   parameter int unsigned NR_STALL_CALL      = 1,
   parameter int unsigned NR_STALL_RETURN    = 1,
   parameter bit          FAULT_ON_UNDERFLOW = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  cfi_log_t                      log_i,
   input  logic                          queue_empty_i,
   output logic                          queue_pop_o,
   input  logic                          flush_i,
   output exception_t                    cfi_fault_o,
   output logic [$clog2(SSTACK_DEPTH):0] sstack_count_o,
   output logic                          overflow_o,
   output logic [31:0]                   perf_calls_o,
   output logic [31:0]                   perf_returns_o,
   output logic [31:0]                   perf_faults_o
);

   localparam int unsigned MAX_STALL = max4(NR_STALL_BRANCH, NR_STALL_JUMP,
                                            NR_STALL_CALL, NR_STALL_RETURN);
   localparam int unsigned STALL_W   = (MAX_STALL == 0) ? 1 : $clog2(MAX_STALL + 1);

   cfi_state_e       state_q, state_d;
   logic [STALL_W-1:0] cnt_q, cnt_d, stall_sel;
   exception_t       fault_q, fault_d;

   logic            do_pop, onehot, is_call, is_ret, mismatch;
   logic [XLEN-1:0] ss_top;
   logic            ss_full, ss_empty;
   logic            unused_sigs;

   // A pop is taken only from IDLE, never under flush or reset
   assign do_pop      = rst_ni && (state_q == ST_IDLE) && !queue_empty_i && !flush_i;
   assign queue_pop_o = do_pop;
   assign onehot      = is_onehot4(log_i.flags);
   assign is_call     = do_pop && onehot && log_i.flags[FLAG_CALL];
   assign is_ret      = do_pop && onehot && log_i.flags[FLAG_RETURN];
   assign mismatch    = is_ret && (ss_empty ? FAULT_ON_UNDERFLOW : (ss_top != log_i.target));
   assign cfi_fault_o = fault_q;
   assign unused_sigs = ^{log_i.pc, ss_full};

   cfi_sstack #(
      .DEPTH (SSTACK_DEPTH)
   ) i_sstack (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (is_call),
      .push_data_i (log_i.next_pc),
      .pop_i       (is_ret),
      .top_o       (ss_top),
      .count_o     (sstack_count_o),
      .full_o      (ss_full),
      .empty_o     (ss_empty),
      .overflow_o  (overflow_o)
   );

   // Processing cycles for the popped log type
   always_comb begin
      stall_sel = '0;
      if      (log_i.flags[FLAG_CALL])   stall_sel = STALL_W'(NR_STALL_CALL);
      else if (log_i.flags[FLAG_RETURN]) stall_sel = STALL_W'(NR_STALL_RETURN);
      else if (log_i.flags[FLAG_JUMP])   stall_sel = STALL_W'(NR_STALL_JUMP);
      else if (log_i.flags[FLAG_BRANCH]) stall_sel = STALL_W'(NR_STALL_BRANCH);
   end

   // Next state, stall counter and one-cycle fault pulse; flush overrides all
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (do_pop && onehot) begin
               if (mismatch) begin
                  state_d       = ST_FAULT;
                  cnt_d         = '0;
                  fault_d.valid = 1'b1;
                  fault_d.cause = CFI_FAULT_CAUSE;
                  fault_d.tval  = log_i.target;
               end else if (stall_sel != '0) begin
                  state_d = ST_BUSY;
                  cnt_d   = stall_sel;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q <= STALL_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - STALL_W'(1);
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         fault_d = '0;
      end
   end

   // FSM, counter and fault registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

`ifdef CFI_BACKEND_PERF_EN
   logic [31:0] calls_q, rets_q, faults_q;

   // Saturating event counters; survive flush, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         calls_q  <= '0;
         rets_q   <= '0;
         faults_q <= '0;
      end else begin
         if (is_call && (calls_q != '1))        calls_q  <= calls_q + 32'd1;
         if (is_ret && (rets_q != '1))          rets_q   <= rets_q + 32'd1;
         if (fault_q.valid && (faults_q != '1)) faults_q <= faults_q + 32'd1;
      end
   end

   assign perf_calls_o   = calls_q;
   assign perf_returns_o = rets_q;
   assign perf_faults_o  = faults_q;
`else
   assign perf_calls_o   = '0;
   assign perf_returns_o = '0;
   assign perf_faults_o  = '0;
`endif

endmodule

// File: tb/tb_cfi_backend_sstack.sv
// Scoreboard bench for cfi_backend_sstack: a driver feeds a model log queue,
// a monitor checks every pop (order, content, spacing) and every fault pulse.
module tb_cfi_backend_sstack;
   import cfi_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam logic [3:0] F_BR = 4'b1000, F_JMP = 4'b0100, F_CALL = 4'b0010, F_RET = 4'b0001;

`ifdef CFI_BACKEND_PERF_EN
   localparam logic [31:0] EXP_CALLS = 32'd2, EXP_RETS = 32'd2, EXP_FAULTS = 32'd1;
`else
   localparam logic [31:0] EXP_CALLS = 32'd0, EXP_RETS = 32'd0, EXP_FAULTS = 32'd0;
`endif

   logic clk = 1'b0, rst_ni = 1'b0, queue_empty_i = 1'b1, flush_i = 1'b0;
   logic queue_pop_o, overflow_o;
   cfi_log_t log_i = '0;
   exception_t cfi_fault_o;
   logic [$clog2(DEPTH):0] sstack_count_o;
   logic [31:0] perf_calls_o, perf_returns_o, perf_faults_o;

   typedef struct {
      cfi_log_t log;
      int       gap;   // expected cycles since previous pop, 0 = don't care
   } exp_t;

   cfi_log_t    logq[$];
   exp_t        exp_pop[$];
   logic [31:0] exp_fault[$];
   int checks = 0, errors = 0, cyc = 0, last_pop = 0;
   bit flush_next = 1'b0;

   cfi_backend_sstack #(
      .SSTACK_DEPTH       (DEPTH),
      .NR_STALL_BRANCH    (1),
      .NR_STALL_JUMP      (1),
      .NR_STALL_CALL      (3),
      .NR_STALL_RETURN    (1),
      .FAULT_ON_UNDERFLOW (1'b1)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .log_i          (log_i),
      .queue_empty_i  (queue_empty_i),
      .queue_pop_o    (queue_pop_o),
      .flush_i        (flush_i),
      .cfi_fault_o    (cfi_fault_o),
      .sstack_count_o (sstack_count_o),
      .overflow_o     (overflow_o),
      .perf_calls_o   (perf_calls_o),
      .perf_returns_o (perf_returns_o),
      .perf_faults_o  (perf_faults_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [3:0] f, input logic [31:0] npc, input logic [31:0] tgt,
                       input int gap, input bit fault);
      cfi_log_t l;
      exp_t     e;
      l.flags = f; l.pc = npc - 32'd4; l.next_pc = npc; l.target = tgt;
      e.log = l; e.gap = gap;
      logq.push_back(l);
      exp_pop.push_back(e);
      if (fault) exp_fault.push_back(tgt);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_pop.size() != 0 || logq.size() != 0) && n < 2000) begin
         settle(1);
         n++;
      end
      chk({name, "_drained"}, 64'(exp_pop.size() + logq.size()), 64'd0);
   endtask

   task automatic do_flush();
      flush_next = 1'b1;
      settle(2);
   endtask

   task automatic calls17();
      for (int i = 1; i <= 17; i++) send(F_CALL, 32'h100 * i, 32'h0, (i == 1) ? 0 : 4, 1'b0);
      drain("calls17");
      settle(5);
      chk("calls17_count", 64'(sstack_count_o), 64'd16);
      chk("calls17_overflow", 64'(overflow_o), 64'd1);
   endtask

   // Driver: presents the model queue head and retires it after a pop edge
   initial begin : drv
      bit popped;
      popped = 1'b0;
      forever begin
         @(negedge clk);
         if (popped && logq.size() != 0) void'(logq.pop_front());
         flush_i       = flush_next;
         flush_next    = 1'b0;
         queue_empty_i = (logq.size() == 0);
         log_i         = (logq.size() != 0) ? logq[0] : '0;
         #1;
         popped = queue_pop_o;
         if (flush_i) chk("flush_cycle_no_pop", 64'(queue_pop_o), 64'd0);
      end
   end

   // Monitor: pops the scoreboard whenever the DUT pops or raises a fault
   initial begin : mon
      exp_t        e;
      logic [31:0] t;
      forever begin
         @(negedge clk);
         #2;
         if (queue_pop_o) begin
            chk("pop_expected", 64'(exp_pop.size() != 0), 64'd1);
            if (exp_pop.size() != 0) begin
               e = exp_pop.pop_front();
               chk("pop_content", 64'(log_i == e.log), 64'd1);
               if (e.gap != 0) chk("pop_spacing", 64'(cyc - last_pop), 64'(e.gap));
            end
            last_pop = cyc;
         end
         if (cfi_fault_o.valid) begin
            chk("fault_expected", 64'(exp_fault.size() != 0), 64'd1);
            if (exp_fault.size() != 0) begin
               t = exp_fault.pop_front();
               chk("fault_tval", 64'(cfi_fault_o.tval), 64'(t));
               chk("fault_cause", 64'(cfi_fault_o.cause), 64'(CFI_FAULT_CAUSE));
            end
         end else begin
            chk("fault_idle_zero", 64'(|cfi_fault_o), 64'd0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      // Reset: nothing pops although the queue holds an entry
      send(F_BR, 32'h10, 32'h20, 0, 1'b0);
      settle(2);
      chk("rst_no_pop", 64'(queue_pop_o), 64'd0);
      chk("rst_count", 64'(sstack_count_o), 64'd0);
      chk("rst_overflow", 64'(overflow_o), 64'd0);
      chk("rst_fault", 64'(|cfi_fault_o), 64'd0);
      chk("rst_perf", 64'(perf_calls_o | perf_returns_o | perf_faults_o), 64'd0);
      rst_ni = 1'b1;
      drain("first");
      settle(3);

      // Call with 3 stall cycles: next pop 4 cycles later; matching return
      send(F_CALL, 32'h1004, 32'h0, 0, 1'b0);
      send(F_BR, 32'h2000, 32'h3000, 4, 1'b0);
      drain("call_stall");
      settle(3);
      chk("call_count", 64'(sstack_count_o), 64'd1);
      send(F_RET, 32'h0, 32'h1004, 0, 1'b0);
      drain("ret_match");
      settle(3);
      chk("ret_match_count", 64'(sstack_count_o), 64'd0);

      // Mismatching return: fault pulse, then FAULT holds the queue until flush
      send(F_CALL, 32'h1004, 32'h0, 0, 1'b0);
      send(F_RET, 32'h0, 32'h2000, 4, 1'b1);
      drain("ret_mismatch");
      settle(2);
      chk("mismatch_count", 64'(sstack_count_o), 64'd0);
      send(F_BR, 32'h40, 32'h44, 0, 1'b0);
      settle(6);
      chk("fault_hold_no_pop", 64'(logq.size()), 64'd1);
      do_flush();
      drain("after_fault_flush");
      settle(2);

      // Overflow then 16 matching returns and an underflow
      calls17();
      for (int i = 17; i >= 2; i--) send(F_RET, 32'h0, 32'h100 * i, (i == 17) ? 0 : 2, 1'b0);
      send(F_RET, 32'h0, 32'hDEAD, 2, 1'b1);
      drain("unwind");
      settle(3);
      chk("unwind_count", 64'(sstack_count_o), 64'd0);
      chk("unwind_overflow_sticky", 64'(overflow_o), 64'd1);
      do_flush();
      chk("flush_overflow", 64'(overflow_o), 64'd0);

      // Malformed flags are popped without touching the stack
      send(F_CALL, 32'h7000, 32'h0, 0, 1'b0);
      send(4'b1100, 32'h5000, 32'h5555, 4, 1'b0);
      send(4'b0011, 32'h6000, 32'h6666, 1, 1'b0);
      send(4'b0000, 32'h0, 32'h0, 1, 1'b0);
      send(F_JMP, 32'h0, 32'h8000, 1, 1'b0);
      send(F_RET, 32'h0, 32'h7000, 2, 1'b0);
      send(F_BR, 32'h0, 32'h9000, 2, 1'b0);
      drain("malformed");
      settle(3);
      chk("malformed_count", 64'(sstack_count_o), 64'd0);

      // Flush coinciding with a non-empty queue in IDLE
      calls17();
      flush_next = 1'b1;
      send(F_BR, 32'h0, 32'hA000, 0, 1'b0);
      settle(2);
      chk("flush_idle_count", 64'(sstack_count_o), 64'd0);
      chk("flush_idle_overflow", 64'(overflow_o), 64'd0);
      drain("flush_idle");
      settle(2);

      // Reset in the middle of BUSY abandons work without a pop
      send(F_CALL, 32'h3000, 32'h0, 0, 1'b0);
      send(F_BR, 32'h0, 32'hB000, 0, 1'b0);
      n = 0;
      while (exp_pop.size() != 1 && n < 100) begin settle(1); n++; end
      settle(1);
      rst_ni = 1'b0;
      settle(1);
      chk("rst_busy_no_pop", 64'(queue_pop_o), 64'd0);
      chk("rst_busy_queue_kept", 64'(logq.size()), 64'd1);
      chk("rst_busy_count", 64'(sstack_count_o), 64'd0);
      rst_ni = 1'b1;
      drain("after_rst");
      settle(2);
      chk("after_rst_count", 64'(sstack_count_o), 64'd0);

      // Performance counters: 2 calls, 2 returns, 1 mismatch
      send(F_CALL, 32'hA0, 32'h0, 0, 1'b0);
      send(F_CALL, 32'hB0, 32'h0, 4, 1'b0);
      send(F_RET, 32'h0, 32'hB0, 4, 1'b0);
      send(F_RET, 32'h0, 32'hC0, 2, 1'b1);
      drain("perf");
      settle(3);
      chk("perf_calls", 64'(perf_calls_o), 64'(EXP_CALLS));
      chk("perf_returns", 64'(perf_returns_o), 64'(EXP_RETS));
      chk("perf_faults", 64'(perf_faults_o), 64'(EXP_FAULTS));
      do_flush();
      chk("perf_kept_on_flush", 64'(perf_calls_o), 64'(EXP_CALLS));
      chk("faults_all_seen", 64'(exp_fault.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfi_backend_sstack.md
CFI_BACKEND_SSTACK -- requirements
Module: cfi_backend_sstack

Interface
REQ-001 SHALL have parameter SSTACK_DEPTH, default 16, number of shadow-stack entries (power of two, >=2).
REQ-002 SHALL have parameters NR_STALL_BRANCH/JUMP/CALL/RETURN, default 1 each, processing cycles per log type (0 allowed).
REQ-003 SHALL have parameter FAULT_ON_UNDERFLOW, default 1, which raises a fault on a return with an empty stack.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 log_i  in  cfi_log_t  queue head: flags[3:0] one-hot {branch,jump,call,return}, pc, next_pc, target.
REQ-007 queue_empty_i  in  1  log queue empty.
REQ-008 queue_pop_o  out  1  pops the queue head this cycle.
REQ-009 flush_i  in  1  clears the stack and the fault state (context switch).
REQ-010 cfi_fault_o  out  exception_t  CFI violation report.
REQ-011 sstack_count_o  out  $clog2(SSTACK_DEPTH)+1  current stack occupancy.
REQ-012 overflow_o  out  1  sticky flag: an entry was lost to an overflow.
REQ-013 perf_calls_o, perf_returns_o, perf_faults_o  out  32 each  event counters.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and FAULT.
REQ-015 IDLE: when !queue_empty_i and !flush_i, SHALL assert queue_pop_o and process log_i in that same cycle.
REQ-016 Counter SHALL load the NR_STALL_x value matching the popped type; nonzero -> BUSY, zero -> remain IDLE (next pop possible the following cycle).
REQ-017 BUSY: no pop; counter decrements each cycle; counter==1 -> IDLE.
REQ-018 Non-one-hot flags SHALL be popped and discarded with no stack operation, staying IDLE.
REQ-019 Call SHALL push log_i.next_pc; when full, SHALL overwrite the oldest entry (circular), keep count at SSTACK_DEPTH, and set overflow_o.
REQ-020 Return SHALL pop the top entry and compare it with log_i.target; on mismatch SHALL enter FAULT.
REQ-021 A return on an empty stack SHALL enter FAULT if FAULT_ON_UNDERFLOW=1; otherwise it SHALL be ignored (no fault).
REQ-022 Branch and jump SHALL cause no stack operation.
REQ-023 cfi_fault_o.valid SHALL pulse for exactly one cycle, the cycle after the offending pop, with cause=CFI_FAULT_CAUSE and tval=offending target; otherwise all fields are 0.
REQ-024 FAULT SHALL not pop and SHALL hold until flush_i.
REQ-025 flush_i (any state) SHALL, next cycle: empty the stack, clear overflow_o, clear the counter and go IDLE; no pop in the flush cycle; flush overrides a simultaneous pop.
REQ-026 The stall counter width SHALL be $clog2(max NR_STALL+1); the stack pointer SHALL wrap modulo SSTACK_DEPTH.

Reset
REQ-027 Reset SHALL put the FSM in IDLE and set the counter, stack pointer, sstack_count_o, overflow_o, cfi_fault_o and all perf counters to 0.
REQ-028 queue_pop_o SHALL be 0 during reset; reset mid-BUSY or mid-FAULT SHALL abandon the operation with no pop.

Configuration
REQ-029 Macro CFI_BACKEND_PERF_EN: defined -> perf counters increment per call pop, return pop and fault pulse, saturating at 2^32-1, and are not cleared by flush_i.
REQ-030 Without CFI_BACKEND_PERF_EN: perf outputs are tied to 0 and no counter flops exist.

Structure
REQ-031 cfi_pkg SHALL hold cfi_log_t, the flag-bit index constants and CFI_FAULT_CAUSE.
REQ-032 The stack storage SHALL be the sub-module cfi_sstack (push/pop/flush, count, full/empty, circular overwrite).

Verification
REQ-033 Call next_pc=0x1004, NR_STALL_CALL=3 -> pop in cycle 0, BUSY 3 cycles, next pop in cycle 4, count=1.
REQ-034 Call 0x1004 then return target 0x1004 -> no fault, count=0; return target 0x2000 -> fault valid 1 cycle, tval=0x2000, FSM in FAULT, no pops until flush.
REQ-035 17 calls with SSTACK_DEPTH=16 -> count=16, overflow_o=1; 16 matching returns succeed, the 17th underflows -> fault.
REQ-036 flags=4'b1100 -> popped, no stack change, next pop the following cycle.
REQ-037 flush_i in the same cycle as a non-empty queue in IDLE -> no pop, next cycle count=0 and overflow_o=0.
REQ-038 With CFI_BACKEND_PERF_EN: 2 calls, 2 returns, 1 mismatch -> perf_calls_o=2, perf_returns_o=2, perf_faults_o=1; without the macro all three read 0.
